ps2_rx_fifo: RTL

PS/2 device-to-host receiver with a parametrised sample divider, full frame checking (start, odd parity, stop), a frame timeout and a show-ahead byte FIFO. It replaces the single-register key latch between the PS/2 pins and consumers such as the seven-segment scan display. Consumers pop bytes, so repeated identical scan codes are never lost.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_byte_fifo.sv | 53 +++++
 rtl/ps2_rx_fifo.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, data width, parity helper
// and the common scan-code prefixes consumers look for.
package ps2_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXTENDED = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    // Parity bit that makes the total number of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead circular byte FIFO; the head entry is visible on rd_data whenever
// the FIFO is not empty. Pushes while full are dropped unless a pop frees a slot.
module ps2_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign count   = CW'(wr_ptr - rd_ptr);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, sample-tick divider, framed
// bit FSM with timeout, feeding a show-ahead byte FIFO for consumers to pop.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 4000,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            PS2C,
    input  logic                            PS2D,
    input  logic                            rd_en,
    output logic [7:0]                      rd_data,
    output logic                            rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            frame_error,
    output logic                            overflow
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int BI_W  = $clog2(DATA_BITS);

    logic             ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
    logic             prev_c;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             fall;

    ps2_state_t           state, state_n;
    logic [BI_W-1:0]      bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_bit_n;
    logic [TO_W-1:0]      to_cnt, to_cnt_n;
    logic                 err_n;
    logic                 push;
    logic                 fifo_full, fifo_empty;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall = tick && !ps2c_s2 && prev_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            ps2c_s1 <= 1'b1;
            ps2c_s2 <= 1'b1;
            ps2d_s1 <= 1'b1;
            ps2d_s2 <= 1'b1;
            prev_c  <= 1'b1;
            div_cnt <= '0;
        end else begin
            ps2c_s1 <= PS2C;
            ps2c_s2 <= ps2c_s1;
            ps2d_s1 <= PS2D;
            ps2d_s2 <= ps2d_s1;
            if (tick) begin
                div_cnt <= '0;
                prev_c  <= ps2c_s2;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            par_bit     <= par_bit_n;
            to_cnt      <= to_cnt_n;
            frame_error <= err_n;
            overflow    <= push && fifo_full && !rd_en;
        end
    end

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        to_cnt_n  = to_cnt;
        err_n     = 1'b0;
        push      = 1'b0;

        // Idle ticks between edges abandon a partial frame once they add up.
        if (state != IDLE && tick && !fall) begin
            if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                state_n  = IDLE;
                to_cnt_n = '0;
                err_n    = 1'b1;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end
        end

        if (fall) begin
            to_cnt_n = '0;
            case (state)
                IDLE: begin
                    if (!ps2d_s2) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                        shreg_n   = '0;
                        par_bit_n = 1'b0;
                    end
                end
                DATA: begin
                    shreg_n = {ps2d_s2, shreg[DATA_BITS-1:1]};
                    if (bit_idx == BI_W'(DATA_BITS - 1))
                        state_n = PARITY;
                    else
                        bit_idx_n = bit_idx + 1'b1;
                end
                PARITY: begin
                    par_bit_n = ps2d_s2;
                    state_n   = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (par_bit == odd_parity(shreg) && ps2d_s2)
                        push = 1'b1;
                    else
                        err_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid = !fifo_empty;

endmodule
